// File: rtl/spi_master_pkg.sv
// Shared types, constants and mode helpers for the single-byte SPI master.
// Mode encoding: CPOL is bit 1, CPHA is bit 0.
package spi_master_pkg;

    typedef enum logic [1:0] {
        IDLE,
        XFER,
        DONE
    } spi_state_t;

    localparam int EDGES_PER_BYTE = 16;
    localparam int BITS_PER_BYTE  = 8;

    function automatic logic cpol(input int unsigned mode);
        return mode[1];
    endfunction

    function automatic logic cpha(input int unsigned mode);
        return mode[0];
    endfunction

endpackage

// File: rtl/spi_master_if.sv
// Byte-stream handshake plus SPI pins for spi_master_top.
// master = design side, slave = client/pin side.
interface spi_master_if;
    import spi_master_pkg::*;

    logic [BITS_PER_BYTE-1:0] i_TX_Byte;
    logic                     i_TX_DV;
    logic                     o_TX_Ready;
    logic                     o_RX_DV;
    logic [BITS_PER_BYTE-1:0] o_RX_Byte;
    logic                     o_SPI_Clk;
    logic                     i_SPI_MISO;
    logic                     o_SPI_MOSI;

    modport master (
        input  i_TX_Byte,
        input  i_TX_DV,
        input  i_SPI_MISO,
        output o_TX_Ready,
        output o_RX_DV,
        output o_RX_Byte,
        output o_SPI_Clk,
        output o_SPI_MOSI
    );

    modport slave (
        output i_TX_Byte,
        output i_TX_DV,
        output i_SPI_MISO,
        input  o_TX_Ready,
        input  o_RX_DV,
        input  o_RX_Byte,
        input  o_SPI_Clk,
        input  o_SPI_MOSI
    );

endinterface

// File: rtl/spi_sclk_gen.sv
// SCLK generator: half-bit divider, edge counter and edge strobes.
// Strobes are high in the cycle whose closing clk edge toggles sclk.
module spi_sclk_gen
    import spi_master_pkg::*;
#(
    parameter bit CPOL              = 1'b0,
    parameter int CLKS_PER_HALF_BIT = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic sclk,
    output logic lead_edge,
    output logic trail_edge,
    output logic last_edge
);

    localparam int HW = $clog2(CLKS_PER_HALF_BIT);
    localparam int EW = $clog2(EDGES_PER_BYTE + 1);
    localparam logic [HW-1:0] HALF_TC = HW'(CLKS_PER_HALF_BIT - 1);
    localparam logic [EW-1:0] LAST_EC = EW'(EDGES_PER_BYTE - 1);

    logic [HW-1:0] half_cnt;
    logic [EW-1:0] edge_cnt;
    logic          tick;

    assign tick = run && (half_cnt == HALF_TC);

    // edge_cnt holds edges already made, so an even count means odd edge
    assign lead_edge  = tick && !edge_cnt[0];
    assign trail_edge = tick && edge_cnt[0];
    assign last_edge  = tick && (edge_cnt == LAST_EC);

    always_ff @(posedge clk) begin
        if (rst || !run) begin
            half_cnt <= '0;
            edge_cnt <= '0;
            sclk     <= CPOL;
        end else if (tick) begin
            half_cnt <= '0;
            edge_cnt <= edge_cnt + EW'(1);
            sclk     <= ~sclk;
        end else begin
            half_cnt <= half_cnt + HW'(1);
        end
    end

endmodule

// File: rtl/spi_master_top.sv
// Single-byte SPI master: FSM plus TX/RX shift registers.
// Define SPI_MASTER_LSB_FIRST_EN to shift LSB first instead of MSB first.
module spi_master_top
    import spi_master_pkg::*;
#(
    parameter int SPI_MODE          = 0,
    parameter int CLKS_PER_HALF_BIT = 2
) (
    input  logic          i_Clk,
    input  logic          i_Rst,
    spi_master_if.master  bus
);

    localparam bit CPOL = cpol(SPI_MODE);
    localparam bit CPHA = cpha(SPI_MODE);

    typedef logic [BITS_PER_BYTE-1:0] byte_t;

`ifdef SPI_MASTER_LSB_FIRST_EN
    function automatic logic head(input byte_t b);
        return b[0];
    endfunction

    function automatic byte_t drop(input byte_t b);
        return {1'b0, b[BITS_PER_BYTE-1:1]};
    endfunction

    function automatic byte_t push(input byte_t b, input logic d);
        return {d, b[BITS_PER_BYTE-1:1]};
    endfunction
`else
    function automatic logic head(input byte_t b);
        return b[BITS_PER_BYTE-1];
    endfunction

    function automatic byte_t drop(input byte_t b);
        return {b[BITS_PER_BYTE-2:0], 1'b0};
    endfunction

    function automatic byte_t push(input byte_t b, input logic d);
        return {b[BITS_PER_BYTE-2:0], d};
    endfunction
`endif

    spi_state_t state_q, state_d;
    byte_t      tx_sr_q, tx_sr_d;
    byte_t      rx_sr_q, rx_sr_d;
    byte_t      rx_byte_q, rx_byte_d;
    logic       mosi_q, mosi_d;
    logic       ready_en_q;
    logic       accept;
    logic       run;
    logic       sclk;
    logic       lead_edge, trail_edge, last_edge;
    logic       sample, shift_out;

    assign accept = bus.i_TX_DV && bus.o_TX_Ready;
    assign run    = (state_q == XFER);
    assign sample = CPHA ? trail_edge : lead_edge;

    // CPHA=0 already drove the MSB on entry; the final trailing edge has no next bit
    assign shift_out = CPHA ? lead_edge : (trail_edge && !last_edge);

    spi_sclk_gen #(
        .CPOL              (CPOL),
        .CLKS_PER_HALF_BIT (CLKS_PER_HALF_BIT)
    ) u_sclk (
        .clk        (i_Clk),
        .rst        (i_Rst),
        .run        (run),
        .sclk       (sclk),
        .lead_edge  (lead_edge),
        .trail_edge (trail_edge),
        .last_edge  (last_edge)
    );

    always_comb begin
        state_d   = state_q;
        tx_sr_d   = tx_sr_q;
        rx_sr_d   = rx_sr_q;
        rx_byte_d = rx_byte_q;
        mosi_d    = mosi_q;
        unique case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                mosi_d  = 1'b0;
                if (accept) begin
                    state_d = XFER;
                    tx_sr_d = bus.i_TX_Byte;
                    mosi_d  = CPHA ? 1'b0 : head(bus.i_TX_Byte);
                end
            end
            XFER: begin
                if (sample) begin
                    rx_sr_d = push(rx_sr_q, bus.i_SPI_MISO);
                end
                if (shift_out) begin
                    tx_sr_d = drop(tx_sr_q);
                    mosi_d  = CPHA ? head(tx_sr_q) : head(tx_sr_d);
                end
                // CPHA=1 samples on the last edge, so take the merged value
                if (last_edge) begin
                    state_d   = DONE;
                    rx_byte_d = rx_sr_d;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state_q    <= IDLE;
            tx_sr_q    <= '0;
            rx_sr_q    <= '0;
            rx_byte_q  <= '0;
            mosi_q     <= 1'b0;
            ready_en_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_sr_q    <= tx_sr_d;
            rx_sr_q    <= rx_sr_d;
            rx_byte_q  <= rx_byte_d;
            mosi_q     <= mosi_d;
            ready_en_q <= 1'b1;
        end
    end

    assign bus.o_TX_Ready = ready_en_q && (state_q != XFER);
    assign bus.o_RX_DV    = (state_q == DONE);
    assign bus.o_RX_Byte  = rx_byte_q;
    assign bus.o_SPI_Clk  = sclk;
    assign bus.o_SPI_MOSI = mosi_q;

endmodule

// File: tb/tb_spi_master_top.sv
// Bench for spi_master_top: one instance per SPI mode, loopback or
// external MISO model on the mode-0 instance.
module tb_spi_master_top;

    logic       clk;
    logic       rst;
    logic [7:0] tx_byte [4];
    logic       tx_dv   [4];
    logic       ready_o [4];
    logic       rx_dv_o [4];
    logic       sclk_o  [4];
    logic       mosi_o  [4];
    logic [7:0] rxb_o   [4];
    logic       ext_en;
    logic [7:0] ext_sr;

    int total = 0;
    int bad   = 0;

    for (genvar g = 0; g < 4; g++) begin : gen_dut
        spi_master_if bus ();

        assign bus.i_TX_Byte  = tx_byte[g];
        assign bus.i_TX_DV    = tx_dv[g];
        assign bus.i_SPI_MISO = (g == 0 && ext_en) ? ext_sr[7]
                                                   : bus.o_SPI_MOSI;
        assign ready_o[g] = bus.o_TX_Ready;
        assign rx_dv_o[g] = bus.o_RX_DV;
        assign sclk_o[g]  = bus.o_SPI_Clk;
        assign mosi_o[g]  = bus.o_SPI_MOSI;
        assign rxb_o[g]   = bus.o_RX_Byte;

        spi_master_top #(
            .SPI_MODE          (g),
            .CLKS_PER_HALF_BIT (2)
        ) u_dut (
            .i_Clk (clk),
            .i_Rst (rst),
            .bus   (bus)
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int         mode;
        logic [7:0] tx;
        bit         ext;
        logic [7:0] eb;
        int         inj;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs [6];

    function automatic logic exp_cpol(input int m);
        return ((m >> 1) & 1) != 0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input int m);
        int n;
        n = 0;
        while (ready_o[m] !== 1'b1 && n < 100) begin
            step();
            n++;
        end
        chk($sformatf("ready_wait_m%0d", m), ready_o[m], 1);
    endtask

    task automatic run_xfer(input vec_t v, input string tag);
        int   m, lat, tog, dvn;
        bit   rdy_ok, mz;
        logic prev;
        logic [7:0] got;
        m = v.mode;
        wait_ready(m);
        chk({tag, "_idle_sclk"}, sclk_o[m], exp_cpol(m));
        ext_en = v.ext;
        ext_sr = v.eb;
        tx_byte[m] = v.tx;
        tx_dv[m] = 1'b1;
        step();
        tx_dv[m] = 1'b0;
        lat = 0; tog = 0; dvn = 0;
        rdy_ok = 1; mz = 1; got = 8'h00;
        prev = sclk_o[m];
        for (int k = 1; k <= 40; k++) begin
            if (sclk_o[m] !== prev) begin
                tog++;
                if (v.ext && prev == 1'b1) ext_sr = {ext_sr[6:0], 1'b0};
            end
            prev = sclk_o[m];
            if (k <= 32 && mosi_o[m] !== 1'b0) mz = 0;
            if (rx_dv_o[m] === 1'b1) begin
                dvn++;
                if (lat == 0) begin
                    lat = k;
                    got = rxb_o[m];
                end
            end
            if (k < 33 && ready_o[m] !== 1'b0) rdy_ok = 0;
            if (v.inj != 0 && k == v.inj) begin
                tx_byte[m] = 8'hFF;
                tx_dv[m] = 1'b1;
            end
            if (v.inj != 0 && k == v.inj + 1) tx_dv[m] = 1'b0;
            step();
        end
        ext_en = 1'b0;
        chk({tag, "_rx_byte"}, got, v.exp);
        chk({tag, "_latency"}, lat, 33);
        chk({tag, "_dv_count"}, dvn, 1);
        chk({tag, "_sclk_edges"}, tog, 16);
        chk({tag, "_ready_low"}, rdy_ok, 1);
        chk({tag, "_rx_hold"}, rxb_o[m], v.exp);
        chk({tag, "_end_sclk"}, sclk_o[m], exp_cpol(m));
        if (v.ext) chk({tag, "_mosi_zero"}, mz, 1);
    endtask

    initial begin
        int   nrx, acc, last, tog, dvs;
        logic prev;
        logic [7:0] seq [3];
        logic [7:0] gotb [3];
        int   gap [3];
        vec_t v77;

        vecs[0] = '{0, 8'hC1, 1'b0, 8'h00, 0, 8'hC1};
        vecs[1] = '{1, 8'h5A, 1'b0, 8'h00, 0, 8'h5A};
        vecs[2] = '{2, 8'h5A, 1'b0, 8'h00, 0, 8'h5A};
        vecs[3] = '{3, 8'h5A, 1'b0, 8'h00, 0, 8'h5A};
        vecs[4] = '{0, 8'h00, 1'b1, 8'h3C, 0, 8'h3C};
        vecs[5] = '{0, 8'h81, 1'b0, 8'h00, 10, 8'h81};

        for (int i = 0; i < 4; i++) begin
            tx_byte[i] = 8'h00;
            tx_dv[i] = 1'b0;
        end
        ext_en = 1'b0;
        ext_sr = 8'h00;
        rst = 1'b1;
        step();
        step();
        step();
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("rst_ready_m%0d", i), ready_o[i], 0);
            chk($sformatf("rst_dv_m%0d", i), rx_dv_o[i], 0);
            chk($sformatf("rst_rxb_m%0d", i), rxb_o[i], 0);
            chk($sformatf("rst_sclk_m%0d", i), sclk_o[i], exp_cpol(i));
            chk($sformatf("rst_mosi_m%0d", i), mosi_o[i], 0);
        end
        rst = 1'b0;
        chk("ready_before_rise", ready_o[0], 0);
        step();
        chk("ready_rise", ready_o[0], 1);

        for (int i = 0; i < 6; i++) begin
            run_xfer(vecs[i], $sformatf("vec%0d", i));
        end

        // streaming C1, A2, B3 with tx_dv held high
        seq[0] = 8'hC1; seq[1] = 8'hA2; seq[2] = 8'hB3;
        for (int i = 0; i < 3; i++) begin
            gotb[i] = 8'h00;
            gap[i] = 0;
        end
        wait_ready(0);
        tx_dv[0] = 1'b1;
        nrx = 0; acc = 0; last = 0;
        for (int c = 0; c < 200 && nrx < 3; c++) begin
            if (rx_dv_o[0] === 1'b1) begin
                gotb[nrx] = rxb_o[0];
                gap[nrx] = c - last;
                last = c;
                nrx++;
            end
            if (ready_o[0] === 1'b1) begin
                if (acc < 3) begin
                    tx_byte[0] = seq[acc];
                    acc++;
                end else begin
                    tx_dv[0] = 1'b0;
                end
            end
            step();
        end
        tx_dv[0] = 1'b0;
        chk("stream_count", nrx, 3);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("stream_byte%0d", i), gotb[i], seq[i]);
            chk($sformatf("stream_gap%0d", i), gap[i], 33);
        end

        // reset after the 5th SCLK edge of an 0xE5 transfer
        wait_ready(0);
        tx_byte[0] = 8'hE5;
        tx_dv[0] = 1'b1;
        step();
        tx_dv[0] = 1'b0;
        tog = 0;
        prev = sclk_o[0];
        for (int k = 0; k < 40 && tog < 5; k++) begin
            step();
            if (sclk_o[0] !== prev) tog++;
            prev = sclk_o[0];
        end
        chk("abort_edges", tog, 5);
        chk("abort_pre_sclk", sclk_o[0], 1);
        chk("abort_pre_mosi", mosi_o[0], 1);
        rst = 1'b1;
        step();
        chk("abort_ready", ready_o[0], 0);
        chk("abort_dv", rx_dv_o[0], 0);
        chk("abort_rxb", rxb_o[0], 0);
        chk("abort_sclk", sclk_o[0], 0);
        chk("abort_mosi", mosi_o[0], 0);
        rst = 1'b0;
        dvs = 0;
        for (int k = 0; k < 40; k++) begin
            if (rx_dv_o[0] === 1'b1) dvs++;
            step();
        end
        chk("abort_no_dv", dvs, 0);
        v77 = '{0, 8'h77, 1'b0, 8'h00, 0, 8'h77};
        run_xfer(v77, "after_abort");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spi_master_top.md
# spi_master_top

Single-byte SPI master with configurable clock mode and SCLK divider. It sits between a byte-stream client (valid/ready handshake) and an external SPI slave. Each accepted byte is shifted out on MOSI while a byte is shifted in from MISO. The received byte is presented with a one-cycle valid pulse. Chip select is out of scope and is handled by the parent.

## Interface
- SPI_MODE, 0: SPI mode 0–3. CPOL = SPI_MODE[1], CPHA = SPI_MODE[0].
- CLKS_PER_HALF_BIT, 2: i_Clk cycles per SCLK half-period. Must be ≥ 2.

- i_Clk  in  1  system clock; all logic on rising edge
- i_Rst  in  1  synchronous, active-high reset
- i_TX_Byte  in  8  byte to transmit, sampled on acceptance
- i_TX_DV  in  1  transmit request; accepted when i_TX_DV & o_TX_Ready
- o_TX_Ready  out  1  idle, can accept a byte
- o_RX_DV  out  1  one-cycle pulse, o_RX_Byte valid
- o_RX_Byte  out  8  last received byte
- o_SPI_Clk  out  1  SCLK
- i_SPI_MISO  in  1  serial data in
- o_SPI_MOSI  out  1  serial data out

## Operation
- FSM states: IDLE, XFER, DONE.
- **IDLE**
  - o_TX_Ready = 1; o_SPI_Clk = CPOL; o_SPI_MOSI = 0.
  - On acceptance: latch i_TX_Byte, clear the edge and bit counters, go to XFER.
- **XFER**
  - o_TX_Ready = 0.
  - A half-bit counter runs 0..CLKS_PER_HALF_BIT-1. At terminal count, o_SPI_Clk toggles; this is one of 16 edges.
  - Edge parity: odd-numbered edges (1,3,…) are leading edges; even-numbered edges are trailing edges.
  - CPHA=0:
    - MSB is driven on MOSI in the first XFER cycle.
    - MISO is sampled on leading edges.
    - The next bit is driven on trailing edges.
  - CPHA=1:
    - Each bit is driven on a leading edge.
    - MISO is sampled on trailing edges.
  - Sampling means MISO is captured on the same i_Clk edge that toggles o_SPI_Clk.
  - Bit order is MSB first, for both TX and RX.
  - After the 16th edge, go to DONE.
- **DONE** (one cycle)
  - o_RX_Byte is updated and o_RX_DV = 1.
  - o_TX_Ready = 1, so a new byte may be accepted in this cycle for back-to-back operation. Acceptance goes to XFER; otherwise go to IDLE.
- i_TX_DV while o_TX_Ready = 0 is ignored; i_TX_Byte is not re-latched.
- i_TX_DV held high streams bytes continuously. The byte present on each acceptance cycle is taken.
- o_RX_Byte holds its value until the next DONE.

## Timing
- Reset values:
  - State = IDLE
  - o_TX_Ready = 0; it rises one cycle after i_Rst deasserts
  - o_RX_DV = 0
  - o_RX_Byte = 8'h00
  - o_SPI_Clk = CPOL
  - o_SPI_MOSI = 0
- Acceptance at cycle N:
  - XFER occupies cycles N+1 .. N+16·CLKS_PER_HALF_BIT.
  - DONE (o_RX_DV = 1) is at cycle N+16·CLKS_PER_HALF_BIT+1.
  - With the default parameters, o_RX_DV occurs 33 cycles after acceptance.
- Back-to-back throughput is 16·CLKS_PER_HALF_BIT + 1 cycles per byte.
- Reset asserted mid-transfer:
  - Aborts immediately to the reset values.
  - No o_RX_DV is generated.
  - o_SPI_Clk returns to CPOL.
- o_SPI_Clk is registered and glitch-free; the duty cycle is exactly 50%.

## Configuration
- SPI_MASTER_LSB_FIRST_EN
  - Defined: TX and RX shift LSB first, i.e. bit 0 is driven and assembled first.
  - Undefined (default): MSB first, as described above.
- The handshake, counts and timing are identical in both builds.

## Structure
- Package spi_master_pkg holds:
  - State enum spi_state_t (IDLE, XFER, DONE).
  - Constants EDGES_PER_BYTE = 16 and BITS_PER_BYTE = 8.
  - Helper functions cpol(mode) and cpha(mode).
- Sub-module spi_sclk_gen is natural. It owns the half-bit counter, the edge counter and o_SPI_Clk, and outputs one-cycle strobes: lead_edge, trail_edge and last_edge.
- The top level holds the FSM and the TX/RX shift registers.

## Test plan
- MOSI looped to MISO, mode 0, default divider; send 0xC1.
  - o_RX_Byte = 0xC1 with a single o_RX_DV pulse 33 cycles after acceptance.
  - o_TX_Ready is low throughout the transfer.
- Loopback, i_TX_DV held high, i_TX_Byte changed to 0xA2 then 0xB3 on each ready cycle.
  - RX sequence C1, A2, B3.
  - 33 cycles between o_RX_DV pulses.
  - No idle gap.
- Loopback in modes 1, 2 and 3 with 0x5A.
  - Received byte is 0x5A.
  - Idle o_SPI_Clk equals CPOL.
  - 8 full SCLK periods per byte.
- External MISO model driving 0x3C while 0x00 is sent (mode 0).
  - o_RX_Byte = 0x3C.
  - MOSI is 0 on every sample edge.
- Second i_TX_DV pulse with 0xFF mid-transfer of 0x81.
  - Ignored: only 0x81 is shifted out, one o_RX_DV.
- i_Rst asserted after the 5th SCLK edge.
  - Outputs return to reset values the next cycle; no o_RX_DV.
  - A following 0x77 transfer completes correctly.
